pat_det_ctrl: RTL and testbench

Controller and sequencer for a programmable serial pattern detector in the bit-stream detection path. It accepts a detection job through a valid/ready config handshake and arms. Once started, it runs the shared matcher over a valid-qualified serial input and counts matches. It stops when a target match count is reached, on abort, or on inactivity timeout.

---
 rtl/pat_det_pkg.sv | 22 ++
 rtl/pat_match_core.sv | 43 ++++
 rtl/pat_det_ctrl.sv | 146 ++++++++++++++
 tb/tb_pat_det_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pat_det_pkg.sv
// Shared types and default sizing for the serial pattern detector.
// The config struct is sized by the DEF_* constants; override top widths only together with these.
package pat_det_pkg;
   localparam int DEF_PAT_W   = 8;
   localparam int DEF_LEN_W   = $clog2(DEF_PAT_W) + 1;
   localparam int DEF_CNT_W   = 8;
   localparam int DEF_TIMEOUT = 255;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [DEF_PAT_W-1:0] pattern;
      logic [DEF_LEN_W-1:0] len;
      logic                 overlap;
      logic [DEF_CNT_W-1:0] target;
   } cfg_t;
endpackage

// File: rtl/pat_match_core.sv
// Serial history shift register with saturating bit count and compare.
// match_now evaluates the post-shift history, so the caller can register it with the shift.
module pat_match_core #(
   parameter int PAT_W = 8,
   parameter int LEN_W = $clog2(PAT_W) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             clr,
   input  logic             keep_on_match,
   input  logic             din,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   output logic             match_now
);
   logic [PAT_W-1:0] hist_q, hist_d, mask;
   logic [LEN_W-1:0] bcnt_q, bcnt_d;

   always_comb begin
      hist_d = {hist_q[PAT_W-2:0], din};
      bcnt_d = (bcnt_q < len) ? bcnt_q + 1'b1 : len;
      mask   = '0;
      for (int i = 0; i < PAT_W; i++) begin
         mask[i] = (i < int'(len));
      end
      match_now = shift_en && (bcnt_d == len) && ((hist_d & mask) == (pattern & mask));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= '0;
         bcnt_q <= '0;
      end else if (clr) begin
         hist_q <= '0;
         bcnt_q <= '0;
      end else if (shift_en) begin
         hist_q <= hist_d;
         // Non-overlapping mode restarts the count so the next match needs len fresh bits.
         bcnt_q <= (match_now && !keep_on_match) ? '0 : bcnt_d;
      end
   end
endmodule

// File: rtl/pat_det_ctrl.sv
// Job controller for the serial pattern detector: config latch, run FSM, match counting.
// Optional idle timeout in RUN is built only when PATDET_TIMEOUT_EN is defined.
module pat_det_ctrl
   import pat_det_pkg::*;
#(
   parameter int PAT_W   = DEF_PAT_W,
   parameter int LEN_W   = $clog2(PAT_W) + 1,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic             start,
   input  logic             abort,
   input  logic             din_valid,
   input  logic             din,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             busy,
   output logic             done,
   output logic             timeout
);
   state_t           state_q;
   cfg_t             cfg_q, cfg_d;
   logic             match_q, done_q;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
   logic [LEN_W-1:0] len_norm;
   logic             match_now, shift_en, run_go;

   always_comb begin
      if (cfg_len == '0)                     len_norm = LEN_W'(1);
      else if (cfg_len > LEN_W'(PAT_W))      len_norm = LEN_W'(PAT_W);
      else                                   len_norm = cfg_len;
      cfg_d       = '{pattern: cfg_pattern, len: len_norm, overlap: cfg_overlap, target: cfg_target};
      match_cnt_d = (&match_cnt_q) ? match_cnt_q : match_cnt_q + 1'b1;
   end

   // A config offer in DONE takes priority over start; abort beats start in ARMED.
   assign run_go   = start && (((state_q == ARMED) && !abort) || ((state_q == DONE) && !cfg_valid));
   assign shift_en = (state_q == RUN) && din_valid && !abort;

   pat_match_core #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_core (
      .clk           (clk),
      .rst           (rst),
      .shift_en      (shift_en),
      .clr           (run_go),
      .keep_on_match (cfg_q.overlap),
      .din           (din),
      .pattern       (cfg_q.pattern),
      .len           (cfg_q.len),
      .match_now     (match_now)
   );

`ifdef PATDET_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] idle_q;
   logic            timeout_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cfg_q       <= '0;
         match_q     <= 1'b0;
         match_cnt_q <= '0;
         done_q      <= 1'b0;
`ifdef PATDET_TIMEOUT_EN
         idle_q      <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         match_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef PATDET_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            IDLE, DONE: begin
               if (cfg_valid) begin
                  cfg_q   <= cfg_d;
                  state_q <= ARMED;
               end else if (run_go) begin
                  state_q     <= RUN;
                  match_cnt_q <= '0;
`ifdef PATDET_TIMEOUT_EN
                  idle_q      <= '0;
`endif
               end
            end
            ARMED: begin
               if (abort) begin
                  state_q <= IDLE;
               end else if (start) begin
                  state_q     <= RUN;
                  match_cnt_q <= '0;
`ifdef PATDET_TIMEOUT_EN
                  idle_q      <= '0;
`endif
               end
            end
            RUN: begin
               if (abort) begin
                  state_q <= IDLE;
               end else if (match_now) begin
                  match_q     <= 1'b1;
                  match_cnt_q <= match_cnt_d;
                  if ((cfg_q.target != '0) && (match_cnt_d == cfg_q.target)) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
`ifdef PATDET_TIMEOUT_EN
               if (!abort) begin
                  if (din_valid) begin
                     idle_q <= '0;
                  end else if (idle_q == TO_W'(TIMEOUT - 1)) begin
                     state_q   <= IDLE;
                     timeout_q <= 1'b1;
                  end else begin
                     idle_q <= idle_q + 1'b1;
                  end
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cfg_ready = (state_q == IDLE) || (state_q == DONE);
   assign busy      = (state_q == RUN);
   assign match     = match_q;
   assign match_cnt = match_cnt_q;
   assign done      = done_q;
`ifdef PATDET_TIMEOUT_EN
   assign timeout   = timeout_q;
`else
   assign timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_pat_det_ctrl.sv
// Bench for pat_det_ctrl: directed job scenarios then random traffic, checked every cycle
// against a bit-history reference model through an expectation queue.
module tb_pat_det_ctrl;
   localparam int PAT_W      = 8;
   localparam int LEN_W      = 4;
   localparam int CNT_W      = 8;
   localparam int TB_TIMEOUT = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cfg_valid, cfg_ready, cfg_overlap;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic [CNT_W-1:0] cfg_target, match_cnt;
   logic             start, abort, din_valid, din;
   logic             match, busy, done, timeout;

   always #5 clk = ~clk;

   pat_det_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .cfg_target(cfg_target), .start(start), .abort(abort), .din_valid(din_valid),
      .din(din), .match(match), .match_cnt(match_cnt), .busy(busy), .done(done),
      .timeout(timeout)
   );

   typedef struct {
      int m, d, t, b, r, c;
   } exp_t;
   exp_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
   endtask

   // Reference model: phase 0 idle, 1 armed, 2 running, 3 finished.
   int m_ph, m_pat, m_len, m_ovl, m_tgt, m_cnt, m_hist, m_nb, m_idle;

   task automatic model_latch();
      m_pat = int'(cfg_pattern);
      m_len = (cfg_len == 0) ? 1 : (int'(cfg_len) > PAT_W ? PAT_W : int'(cfg_len));
      m_ovl = int'(cfg_overlap);
      m_tgt = int'(cfg_target);
      m_ph  = 1;
   endtask

   task automatic model_run();
      m_ph = 2; m_cnt = 0; m_hist = 0; m_nb = 0; m_idle = 0;
   endtask

   task automatic model_step();
      exp_t e;
      int mt = 0, dn = 0, to = 0, mask;
      if (rst) begin
         m_ph = 0; m_cnt = 0; m_hist = 0; m_nb = 0; m_idle = 0;
         m_pat = 0; m_len = 0; m_ovl = 0; m_tgt = 0;
      end else begin
         case (m_ph)
            0: if (cfg_valid) model_latch();
            1: if (abort) m_ph = 0; else if (start) model_run();
            2: begin
               if (abort) m_ph = 0;
               else if (din_valid) begin
                  m_idle = 0;
                  m_hist = ((m_hist << 1) | int'(din)) & 255;
                  m_nb++;
                  mask = (1 << m_len) - 1;
                  if (m_nb >= m_len && (m_hist & mask) == (m_pat & mask)) begin
                     mt = 1;
                     if (m_cnt < 255) m_cnt++;
                     if (m_ovl == 0) m_nb = 0;
                     if (m_tgt != 0 && m_cnt == m_tgt) begin
                        m_ph = 3; dn = 1;
                     end
                  end
               end else begin
`ifdef PATDET_TIMEOUT_EN
                  m_idle++;
                  if (m_idle == TB_TIMEOUT) begin
                     m_ph = 0; to = 1;
                  end
`endif
               end
            end
            default: if (cfg_valid) model_latch(); else if (start) model_run();
         endcase
      end
      e.m = mt; e.d = dn; e.t = to; e.c = m_cnt;
      e.b = (m_ph == 2) ? 1 : 0;
      e.r = (m_ph == 0 || m_ph == 3) ? 1 : 0;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic send_bits(input logic [7:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         din_valid = 1'b1;
         din = bits[i];
         tick();
      end
      din_valid = 1'b0;
      din = 1'b0;
   endtask

   task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                           input logic [7:0] tgt);
      cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_target = tgt;
      tick();
      cfg_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Monitor: one expectation per clock edge, compared at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rst) begin
               e.m = 0; e.d = 0; e.t = 0; e.b = 0; e.r = 1; e.c = 0;
            end
            check("match", int'(match), e.m);
            check("done", int'(done), e.d);
            check("timeout", int'(timeout), e.t);
            check("busy", int'(busy), e.b);
            check("cfg_ready", int'(cfg_ready), e.r);
            check("match_cnt", int'(match_cnt), e.c);
         end
      end
   end

   initial begin
      cfg_valid = 1'b1; cfg_pattern = 8'b0000_1010; cfg_len = 4'd4; cfg_overlap = 1'b1;
      cfg_target = 8'd0; start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      check("rdy_before_accept", int'(cfg_ready), 1);
      tick();
      check("rdy_after_accept", int'(cfg_ready), 0);
      cfg_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      send_bits(8'b0101_0101, 7);
      check("overlap_cnt", int'(match_cnt), 2);
      check("overlap_busy", int'(busy), 1);
      abort = 1'b1; tick(); abort = 1'b0;

      load_cfg(8'b0000_1010, 4'd4, 1'b0, 8'd0);
      send_bits(8'b0101_0101, 7);
      check("nonoverlap_cnt", int'(match_cnt), 1);
      abort = 1'b1; tick(); abort = 1'b0;

      load_cfg(8'b0000_1010, 4'd4, 1'b1, 8'd2);
      send_bits(8'b0010_1010, 6);
      check("target_ready", int'(cfg_ready), 1);
      check("target_busy", int'(busy), 0);
      tick();

      load_cfg(8'b0000_1010, 4'd4, 1'b1, 8'd0);
      send_bits(8'b0101_0101, 7);
      din_valid = 1'b1; din = 1'b0; abort = 1'b1;
      tick();
      din_valid = 1'b0; abort = 1'b0;
      check("abort_cnt", int'(match_cnt), 2);
      check("abort_match", int'(match), 0);
      check("abort_idle", int'(cfg_ready), 1);

      load_cfg(8'b0000_0001, 4'd0, 1'b0, 8'd0);
      send_bits(8'b0000_1101, 4);
      check("len0_cnt", int'(match_cnt), 3);
`ifdef PATDET_TIMEOUT_EN
      repeat (TB_TIMEOUT + 2) tick();
      check("timeout_idle", int'(busy), 0);
`else
      abort = 1'b1; tick(); abort = 1'b0;
`endif

      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 599) == 0);
         cfg_valid   = ($urandom_range(0, 7) == 0);
         cfg_pattern = 8'($urandom);
         cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(0, 3));
         cfg_overlap = 1'($urandom);
         cfg_target  = 8'($urandom_range(0, 3));
         start       = ($urandom_range(0, 5) == 0);
         abort       = ($urandom_range(0, 39) == 0);
         din_valid   = ($urandom_range(0, 3) != 0);
         din         = 1'($urandom);
         tick();
      end
      rst = 1'b0; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; din_valid = 1'b0;
      tick();
      @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
